// File: rtl/boule_multi_layer.sv
// rtl/boule_multi_layer.sv - hopping ball sprite on the cube pyramid; BOULE_FREEZE_EN enables e_freeze in MOVE
module boule_multi_layer #(
    parameter int N_HOPS        = 7,
    parameter int SPEED_W       = 32,
    parameter int DEFAULT_SPEED = 100000,
    parameter int SPAWN_BIT     = 16,
    parameter int X_MAX         = 800
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        x_cnt,
    input  logic [9:0]         y_cnt,
    input  logic [10:0]        XDIAG_DEMI,
    input  logic [10:0]        XLENGTH,
    input  logic [9:0]         YDIAG_DEMI,
    input  logic               e_enable,
    input  logic [N_HOPS-1:0]  e_move,
    input  logic [20:0]        e_XY0,
    input  logic               e_pause,
    input  logic               e_resume,
    input  logic               e_restart,
    input  logic [SPEED_W-1:0] e_speed,
    input  logic               e_freeze,
    input  logic               qbert_hitbox,
    output logic [20:0]        boule_xy,
    output logic               boule_hitbox,
    output logic               la_boule,
    output logic               done_move,
    output logic               hit_qb,
    output logic [2:0]         br_state,
    output logic               busy
);
    localparam int HOP_W = $clog2(N_HOPS + 1);
    localparam logic [10:0] X_LIM = 11'(X_MAX);
    localparam logic [SPEED_W-1:0] ONE = {{(SPEED_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, MOVE = 3'd2, FALL = 3'd3, DONE = 3'd4} state_t;
    state_t state, state_nxt;

    logic [SPEED_W-1:0] count, speed, count_nxt, speed_sel;
    logic [10:0]        x0, xc, xc_disp, start_x, xq;
    logic [9:0]         y0, yc, yc_disp, yq;
    logic [HOP_W-1:0]   hop_cnt;
    logic [N_HOPS-1:0]  move_vec;
    logic [11:0]        step_cnt;
    logic               phase_h, paused, hold, frz, tick, spawn, spawn_rise;
    logic               v_last, h_last, hop_end, busy_st, in_box, hitbox_r, hit_latch;

    always_comb begin
        hold = e_pause | (paused & ~e_resume);
`ifdef BOULE_FREEZE_EN
        frz = e_freeze & (state == MOVE);
`else
        frz = 1'b0 & e_freeze;
`endif
        speed_sel  = (e_speed == '0) ? SPEED_W'(DEFAULT_SPEED) : e_speed;
        spawn      = ~hold & e_enable & ((state == IDLE) | (state == DONE));
        tick       = ~hold & ~frz & (count == speed);
        count_nxt  = tick ? '0 : count + ONE;
        spawn_rise = count_nxt[SPAWN_BIT] & ~count[SPAWN_BIT];
        move_vec   = e_move >> hop_cnt;
        v_last     = (step_cnt + 12'd1) >= {2'b00, YDIAG_DEMI};
        h_last     = (step_cnt + 12'd1) >= ({1'b0, XDIAG_DEMI} + {1'b0, XLENGTH});
        hop_end    = (state == MOVE) & tick & phase_h & h_last;
        busy_st    = (state == START) | (state == MOVE) | (state == FALL);
        // during the slide the position is derived from the anchor, afterwards it is the running xc/yc
        xc_disp    = (state == START) ? (x0 - XLENGTH + start_x) : xc;
        yc_disp    = (state == START) ? (y0 + YDIAG_DEMI) : yc;
        xq         = XDIAG_DEMI >> 2;
        yq         = YDIAG_DEMI >> 2;
        in_box     = (x_cnt >= xc_disp - xq) & (x_cnt <= xc_disp + xq) &
                     (y_cnt >= yc_disp - yq) & (y_cnt <= yc_disp + yq);
    end

    always_comb begin
        state_nxt = state;
        if (e_restart) begin
            state_nxt = IDLE;
        end else if (!hold) begin
            case (state)
                IDLE, DONE: if (e_enable) state_nxt = START;
                START:      if (start_x == XLENGTH) state_nxt = MOVE;
                MOVE:       if (hop_end && hop_cnt == HOP_W'(N_HOPS - 1)) state_nxt = FALL;
                FALL:       if (xc >= X_LIM) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0; speed <= SPEED_W'(DEFAULT_SPEED); paused <= 1'b0;
            x0 <= '0; y0 <= '0; xc <= '0; yc <= '0; start_x <= '0;
            hop_cnt <= '0; step_cnt <= '0; phase_h <= 1'b0;
            hitbox_r <= 1'b0; hit_latch <= 1'b0; hit_qb <= 1'b0; done_move <= 1'b0;
        end else if (e_restart) begin
            count <= '0; speed <= SPEED_W'(DEFAULT_SPEED); paused <= 1'b0;
            x0 <= '0; y0 <= '0; xc <= '0; yc <= '0; start_x <= '0;
            hop_cnt <= '0; step_cnt <= '0; phase_h <= 1'b0;
            hitbox_r <= 1'b0; hit_latch <= 1'b0; hit_qb <= 1'b0; done_move <= 1'b0;
        end else begin
            paused    <= hold;
            done_move <= hop_end;
            hitbox_r  <= in_box & busy_st;
            hit_qb    <= 1'b0;
            if (boule_hitbox && qbert_hitbox && state == MOVE && !hit_latch) begin
                hit_qb    <= 1'b1;
                hit_latch <= 1'b1;
            end
            if (spawn) begin
                x0 <= e_XY0[20:10]; y0 <= e_XY0[9:0];
                start_x <= '0; hop_cnt <= '0; step_cnt <= '0; phase_h <= 1'b0;
                hit_latch <= 1'b0; count <= '0; speed <= speed_sel;
            end else if (!hold) begin
                if (!frz) count <= count_nxt;
                if (tick) speed <= speed_sel;
                case (state)
                    START: begin
                        if (start_x == XLENGTH) begin
                            xc <= x0;
                            yc <= y0 + YDIAG_DEMI;
                        end else if (spawn_rise) begin
                            start_x <= start_x + 11'd1;
                        end
                    end
                    MOVE: if (tick) begin
                        if (!phase_h) begin
                            yc <= move_vec[0] ? yc + 10'd1 : yc - 10'd1;
                            step_cnt <= v_last ? 12'd0 : step_cnt + 12'd1;
                            phase_h  <= v_last;
                        end else begin
                            xc <= xc + 11'd1;
                            step_cnt <= h_last ? 12'd0 : step_cnt + 12'd1;
                            phase_h  <= ~h_last;
                            if (h_last) hop_cnt <= hop_cnt + HOP_W'(1);
                        end
                    end
                    FALL: if (xc < X_LIM && tick) xc <= xc + 11'd1;
                    default: ;
                endcase
            end
        end
    end

    assign boule_xy     = {xc_disp, yc_disp};
    assign boule_hitbox = hitbox_r & busy_st;
    assign la_boule     = boule_hitbox;
    assign br_state     = state;
    assign busy         = busy_st;
endmodule

// File: tb/tb_boule_multi_layer.sv
// tb/tb_boule_multi_layer.sv - randomized check of boule_multi_layer against a behavioural model
module tb_boule_multi_layer;
    localparam int NH = 3, SW = 8, DEF = 5, SB = 1, XMAX = 140;
    localparam int XL = 6, XD = 4, YD = 8;
`ifdef BOULE_FREEZE_EN
    localparam bit FRZ = 1'b1;
`else
    localparam bit FRZ = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0;
    logic [10:0] x_cnt = '0;
    logic [9:0]  y_cnt = '0;
    logic [10:0] XDIAG_DEMI = 11'(XD), XLENGTH = 11'(XL);
    logic [9:0]  YDIAG_DEMI = 10'(YD);
    logic e_enable = 0, e_pause = 0, e_resume = 0, e_restart = 0, e_freeze = 0, qbert_hitbox = 0;
    logic [NH-1:0] e_move = '0;
    logic [20:0] e_XY0 = '0;
    logic [SW-1:0] e_speed = '0;
    logic [20:0] boule_xy;
    logic boule_hitbox, la_boule, done_move, hit_qb, busy;
    logic [2:0] br_state;

    boule_multi_layer #(.N_HOPS(NH), .SPEED_W(SW), .DEFAULT_SPEED(DEF), .SPAWN_BIT(SB), .X_MAX(XMAX)) dut (
        .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .XDIAG_DEMI(XDIAG_DEMI), .XLENGTH(XLENGTH), .YDIAG_DEMI(YDIAG_DEMI),
        .e_enable(e_enable), .e_move(e_move), .e_XY0(e_XY0), .e_pause(e_pause),
        .e_resume(e_resume), .e_restart(e_restart), .e_speed(e_speed), .e_freeze(e_freeze),
        .qbert_hitbox(qbert_hitbox), .boule_xy(boule_xy), .boule_hitbox(boule_hitbox),
        .la_boule(la_boule), .done_move(done_move), .hit_qb(hit_qb), .br_state(br_state), .busy(busy));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    // reference state: states as 0..4, hop progress as pixels walked so far in the current hop
    int m_st, m_cnt, m_spd, m_sx, m_x, m_y, m_x0, m_y0, m_hop, m_prog;
    int m_paused, m_latch, m_hbr, m_done, m_hit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dispx();
        return (m_st == 1) ? ((m_x0 - XL + m_sx) & 2047) : m_x;
    endfunction
    function automatic int dispy();
        return (m_st == 1) ? ((m_y0 + YD) & 1023) : m_y;
    endfunction
    function automatic int model_xy();
        return (dispx() << 10) | dispy();
    endfunction
    function automatic int in_win(input int v, input int c, input int q, input int m);
        int lo, hi;
        lo = (c - q + m) % m;
        hi = (c + q) % m;
        return int'(v >= lo && v <= hi);
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_spd = DEF; m_sx = 0; m_x = 0; m_y = 0; m_x0 = 0; m_y0 = 0;
        m_hop = 0; m_prog = 0; m_paused = 0; m_latch = 0; m_hbr = 0; m_done = 0; m_hit = 0;
    endtask

    task automatic model_step();
        int dx, dy, bpre, hold, frz, tk, old, rise, dir;
        if (!reset || e_restart) begin
            model_reset();
            return;
        end
        dx = dispx(); dy = dispy();
        bpre = int'(m_st >= 1 && m_st <= 3);
        m_hit = 0;
        if (m_hbr && bpre && qbert_hitbox && m_st == 2 && !m_latch) begin
            m_hit = 1; m_latch = 1;
        end
        m_hbr = in_win(int'(x_cnt), dx, XD / 4, 2048) && in_win(int'(y_cnt), dy, YD / 4, 1024) && bpre;
        hold = int'(e_pause || (m_paused && !e_resume));
        m_paused = hold;
        frz = int'(FRZ && e_freeze && m_st == 2);
        m_done = 0;
        if (hold) return;
        if ((m_st == 0 || m_st == 4) && e_enable) begin
            m_x0 = int'(e_XY0[20:10]); m_y0 = int'(e_XY0[9:0]);
            m_sx = 0; m_hop = 0; m_prog = 0; m_latch = 0; m_cnt = 0;
            m_spd = (e_speed == 0) ? DEF : int'(e_speed);
            m_st = 1;
            return;
        end
        tk = int'(!frz && m_cnt == m_spd);
        rise = 0;
        if (!frz) begin
            old = m_cnt;
            m_cnt = tk ? 0 : m_cnt + 1;
            rise = int'(((m_cnt >> SB) & 1) == 1 && ((old >> SB) & 1) == 0);
        end
        if (tk) m_spd = (e_speed == 0) ? DEF : int'(e_speed);
        case (m_st)
            1: if (m_sx == XL) begin
                   m_st = 2; m_x = m_x0; m_y = (m_y0 + YD) & 1023;
               end else if (rise) m_sx++;
            2: if (tk) begin
                   dir = (int'(e_move) >> m_hop) & 1;
                   if (m_prog < YD) m_y = dir ? (m_y + 1) & 1023 : (m_y + 1023) & 1023;
                   else m_x = (m_x + 1) & 2047;
                   m_prog++;
                   if (m_prog == YD + XD + XL) begin
                       m_prog = 0; m_done = 1; m_hop++;
                       if (m_hop == NH) m_st = 3;
                   end
               end
            3: if (m_x >= XMAX) m_st = 4;
               else if (tk) m_x++;
            default: ;
        endcase
    endtask

    task automatic compare_all();
        int b;
        b = int'(m_st >= 1 && m_st <= 3);
        check_eq("boule_xy", boule_xy, model_xy());
        check_eq("br_state", br_state, m_st);
        check_eq("busy", busy, b);
        check_eq("boule_hitbox", boule_hitbox, int'(m_hbr && b));
        check_eq("la_boule", la_boule, int'(m_hbr && b));
        check_eq("done_move", done_move, m_done);
        check_eq("hit_qb", hit_qb, m_hit);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic spawn_and_reach_move(input int extra);
        e_enable = 1; step(); e_enable = 0;
        for (int i = 0; i < 400 && m_st != 2; i++) step();
        repeat (extra) step();
    endtask

    initial begin
        int hits, dones, got_slide, snap;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        check_eq("rst_xy", boule_xy, 0);
        check_eq("rst_state", br_state, 0);
        reset = 1;

        // full run: slide, three hops, fall, collision held on the ball
        e_speed = 8'd2; e_XY0 = {11'd100, 10'd180}; e_move = 3'b001; qbert_hitbox = 1;
        e_enable = 1; step(); e_enable = 0;
        hits = 0; dones = 0; got_slide = 0;
        for (int i = 0; i < 3000 && m_st != 4; i++) begin
            x_cnt = 11'(dispx()); y_cnt = 10'(dispy());
            e_enable = 1'($urandom_range(0, 1));
            step();
            hits += int'(hit_qb); dones += int'(done_move);
            if (!got_slide && br_state == 3'd2) begin
                got_slide = 1;
                check_eq("slide_x", boule_xy[20:10], 100);
                check_eq("slide_y", boule_xy[9:0], 188);
            end
        end
        e_enable = 0;
        check_eq("slide_seen", got_slide, 1);
        check_eq("hit_once", hits, 1);
        check_eq("hop_count", dones, NH);
        check_eq("end_state", br_state, 4);
        check_eq("end_x", boule_xy[20:10], XMAX);
        check_eq("end_la_boule", la_boule, 0);
        check_eq("end_busy", busy, 0);

        // pause mid-hop, resume, then restart racing pause and enable
        qbert_hitbox = 0; e_speed = 8'd3;
        spawn_and_reach_move(20);
        e_pause = 1; step(); e_pause = 0;
        snap = model_xy();
        repeat (1000) step();
        check_eq("pause_xy", boule_xy, snap);
        check_eq("pause_state", br_state, 2);
        e_resume = 1; step(); e_resume = 0;
        repeat (300) step();
        e_restart = 1; e_pause = 1; e_enable = 1; step();
        e_restart = 0; e_pause = 0; e_enable = 0;
        check_eq("restart_state", br_state, 0);
        check_eq("restart_xy", boule_xy, 0);

        // freeze in MOVE with the ball under qbert
        spawn_and_reach_move(12);
        e_freeze = 1; qbert_hitbox = 1; hits = 0; dones = 0;
        repeat (500) begin
            x_cnt = 11'(dispx()); y_cnt = 10'(dispy());
            step();
            hits += int'(hit_qb); dones += m_hit;
        end
        e_freeze = 0; qbert_hitbox = 0;
        check_eq("freeze_xy", boule_xy, model_xy());
        check_eq("freeze_hit", hits, dones);

        // asynchronous reset in the middle of a hop
        e_restart = 1; step(); e_restart = 0;
        spawn_and_reach_move(15);
        #2 reset = 0;
        model_reset();
        #1 compare_all();
        repeat (3) step();
        reset = 1;
        step();

        for (int i = 0; i < 12000; i++) begin
            e_enable  = 1'($urandom_range(0, 19) == 0);
            e_pause   = 1'($urandom_range(0, 99) == 0);
            e_resume  = 1'($urandom_range(0, 29) == 0);
            e_restart = 1'($urandom_range(0, 1999) == 0);
            e_freeze  = 1'($urandom_range(0, 3) == 0);
            qbert_hitbox = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) e_move = NH'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: e_speed = 8'd0;
                    1: e_speed = 8'd2;
                    2: e_speed = 8'd3;
                    default: e_speed = 8'd4;
                endcase
            end
            e_XY0 = {11'($urandom_range(90, 105)), 10'($urandom_range(100, 400))};
            x_cnt = 11'((dispx() + $urandom_range(0, 4) + 2046) & 2047);
            y_cnt = 10'((dispy() + $urandom_range(0, 6) + 1021) & 1023);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
